// File: rtl/halfband_interp_if.sv
// Stream, coefficient-load and output bundle for the halfband interpolator.
// The master side drives samples and taps; the slave side returns both output phases.
interface halfband_interp_if #(
    parameter int NCH  = 4,
    parameter int NDSP = 3
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic                   sync;
    logic signed [23:0]     id;
    logic signed [17:0]     tap;
    logic [NDSP-1:0]        load_tap;
    logic signed [23:0]     od0;
    logic signed [23:0]     od1;
    logic                   ovalid;
    logic [CW-1:0]          och;

    modport master (
        output sync, id, tap, load_tap,
        input  od0, od1, ovalid, och
    );

    modport slave (
        input  sync, id, tap, load_tap,
        output od0, od1, ovalid, och
    );
endinterface

// File: rtl/halfband_interp.sv
// Halfband interpolate-by-2 FIR for TDM streams: one sample in, FIR and centre phases out.
// Systolic pre-add/multiply/accumulate chain, one stage per unique coefficient.
module halfband_interp #(
    parameter int NCH  = 4,
    parameter int NDSP = 3
) (
    input  logic             c,
    input  logic             rst_n,
    halfband_interp_if.slave bus
);
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NHIST = 2 * NDSP;
    localparam int DLY   = NDSP + 1;
    localparam logic signed [47:0] RND = 48'sd32768;

    function automatic logic signed [23:0] sat24(input logic signed [47:0] v);
        logic signed [23:0] r;
        if (v > 48'sd8388607) begin
            r = 24'sh7FFFFF;
        end else if (v < -48'sd8388608) begin
            r = 24'sh800000;
        end else begin
            r = v[23:0];
        end
        return r;
    endfunction

    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cur_ch_s;
    logic [CW-1:0]          nxt_ch_s;
    logic                   started_r;
    logic signed [23:0]     hist_r [NCH][NHIST-1];
    logic signed [23:0]     x_r [NHIST];
    logic                   s1_vld_r;
    logic [CW-1:0]          s1_ch_r;
    logic signed [17:0]     coef_r [NDSP];
    logic [NDSP-1:0][47:0]  acc_s;
    logic                   vld_d_r [DLY];
    logic [CW-1:0]          ch_d_r [DLY];
    logic signed [23:0]     ctr_d_r [DLY];
    logic signed [23:0]     od0_r;
    logic signed [23:0]     od1_r;
    logic                   ovalid_r;
    logic [CW-1:0]          och_r;

    // Channel of the sample on id this cycle, and the counter value that follows it.
    always_comb begin
        cur_ch_s = cnt_r;
        nxt_ch_s = '0;
        if (bus.sync) begin
            cur_ch_s = '0;
        end else begin
            cur_ch_s = cnt_r;
        end
        if (cur_ch_s == CW'(NCH - 1)) begin
            nxt_ch_s = '0;
        end else begin
            nxt_ch_s = cur_ch_s + CW'(1);
        end
    end

    // Capture stage: per-channel history read-modify-write and the full tap window.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= '0;
            started_r <= 1'b0;
            s1_vld_r  <= 1'b0;
            s1_ch_r   <= '0;
            for (int j = 0; j < NHIST; j++) begin
                x_r[j] <= '0;
            end
            for (int ch = 0; ch < NCH; ch++) begin
                for (int j = 0; j < NHIST - 1; j++) begin
                    hist_r[ch][j] <= '0;
                end
            end
        end else begin
            cnt_r     <= nxt_ch_s;
            started_r <= started_r | bus.sync;
            s1_vld_r  <= started_r | bus.sync;
            s1_ch_r   <= cur_ch_s;
            x_r[0]    <= bus.id;
            for (int j = 1; j < NHIST; j++) begin
                x_r[j] <= hist_r[cur_ch_s][j-1];
            end
            hist_r[cur_ch_s][0] <= bus.id;
            for (int j = 1; j < NHIST - 1; j++) begin
                hist_r[cur_ch_s][j] <= hist_r[cur_ch_s][j-1];
            end
        end
    end

    // Coefficient bank; several strobes may land on the same edge.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NDSP; k++) begin
                coef_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NDSP; k++) begin
                if (bus.load_tap[k]) begin
                    coef_r[k] <= bus.tap;
                end
            end
        end
    end

    // Tap k sees its operand pair delayed k cycles so the partial sum meets it in step.
    for (genvar k = 0; k < NDSP; k++) begin : g_tap
        logic signed [23:0] a_s;
        logic signed [23:0] b_s;
        logic signed [24:0] pa_s;
        logic signed [42:0] m_r;
        logic signed [47:0] acc_r;
        logic signed [47:0] acc_in_s;

        if (k == 0) begin : g_head
            assign a_s      = x_r[0];
            assign b_s      = x_r[NHIST-1];
            assign acc_in_s = RND;
        end else begin : g_body
            logic signed [23:0] a_d_r [k];
            logic signed [23:0] b_d_r [k];

            // Systolic operand delay for this tap.
            always_ff @(posedge c or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < k; i++) begin
                        a_d_r[i] <= '0;
                        b_d_r[i] <= '0;
                    end
                end else begin
                    a_d_r[0] <= x_r[k];
                    b_d_r[0] <= x_r[NHIST-1-k];
                    for (int i = 1; i < k; i++) begin
                        a_d_r[i] <= a_d_r[i-1];
                        b_d_r[i] <= b_d_r[i-1];
                    end
                end
            end

            assign a_s      = a_d_r[k-1];
            assign b_s      = b_d_r[k-1];
            assign acc_in_s = $signed(acc_s[k-1]);
        end

        assign pa_s = {a_s[23], a_s} + {b_s[23], b_s};

        // Multiply and accumulate registers for this tap.
        always_ff @(posedge c or negedge rst_n) begin
            if (!rst_n) begin
                m_r   <= '0;
                acc_r <= '0;
            end else begin
                m_r   <= $signed({{25{coef_r[k][17]}}, coef_r[k]}) * $signed({{18{pa_s[24]}}, pa_s});
                acc_r <= acc_in_s + {{5{m_r[42]}}, m_r};
            end
        end

        assign acc_s[k] = acc_r;
    end

    // Valid, channel and centre sample ride alongside the MAC chain.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DLY; i++) begin
                vld_d_r[i] <= 1'b0;
                ch_d_r[i]  <= '0;
                ctr_d_r[i] <= '0;
            end
        end else begin
            vld_d_r[0] <= s1_vld_r;
            ch_d_r[0]  <= s1_ch_r;
            ctr_d_r[0] <= x_r[NDSP-1];
            for (int i = 1; i < DLY; i++) begin
                vld_d_r[i] <= vld_d_r[i-1];
                ch_d_r[i]  <= ch_d_r[i-1];
                ctr_d_r[i] <= ctr_d_r[i-1];
            end
        end
    end

    // Output register; the shift by 16 rather than 17 folds in the interpolation gain of 2.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            od0_r    <= '0;
            od1_r    <= '0;
            ovalid_r <= 1'b0;
            och_r    <= '0;
        end else begin
            ovalid_r <= vld_d_r[DLY-1];
            if (vld_d_r[DLY-1]) begin
                od0_r <= sat24($signed(acc_s[NDSP-1]) >>> 16);
                od1_r <= ctr_d_r[DLY-1];
                och_r <= ch_d_r[DLY-1];
            end else begin
                od0_r <= '0;
                od1_r <= '0;
                och_r <= '0;
            end
        end
    end

    assign bus.od0    = od0_r;
    assign bus.od1    = od1_r;
    assign bus.ovalid = ovalid_r;
    assign bus.och    = och_r;
endmodule

// File: tb/tb_halfband_interp.sv
// Directed-vector bench for halfband_interp: reset, impulse, DC gain, saturation, resync, tap reload.
module tb_halfband_interp;
    localparam int NCH  = 4;
    localparam int NDSP = 3;
    localparam int LAT  = NDSP + 3;
    localparam int OFS  = LAT - 1;

    logic c = 1'b0;
    logic rst_n;

    always #5 c = ~c;

    halfband_interp_if #(.NCH(NCH), .NDSP(NDSP)) bus ();

    halfband_interp #(.NCH(NCH), .NDSP(NDSP)) dut (
        .c     (c),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic signed [23:0] log_od0 [512];
    logic signed [23:0] log_od1 [512];
    logic               log_vld [512];
    logic [1:0]         log_och [512];

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic run_cycle(input logic s, input logic signed [23:0] d);
        bus.sync = s;
        bus.id   = d;
        tick();
        log_od0[cyc] = bus.od0;
        log_od1[cyc] = bus.od1;
        log_vld[cyc] = bus.ovalid;
        log_och[cyc] = bus.och;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.sync     = 1'b0;
        bus.id       = 24'sd0;
        bus.tap      = 18'sd0;
        bus.load_tap = 3'b000;
        repeat (3) tick();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic set_coefs(input int c0, input int c1, input int c2);
        bus.tap = 18'(c0); bus.load_tap = 3'b001; tick();
        bus.tap = 18'(c1); bus.load_tap = 3'b010; tick();
        bus.tap = 18'(c2); bus.load_tap = 3'b100; tick();
        bus.load_tap = 3'b000;
    endtask

    task automatic play_impulse(input bit reload);
        for (int i = 0; i < 36; i++) begin
            if (reload && i == 2) begin
                bus.tap      = 18'(-5000);
                bus.load_tap = 3'b010;
            end else begin
                bus.load_tap = 3'b000;
            end
            run_cycle(i == 0, (i == 0) ? 24'sd65536 : 24'sd0);
        end
        bus.load_tap = 3'b000;
        bus.sync     = 1'b0;
    endtask

    task automatic test_reset();
        int s;
        do_reset();
        set_coefs(1000, 2000, 4000);
        for (int i = 0; i < 36; i++) run_cycle(i == 0, 24'sd100);
        bus.sync = 1'b0;
        checks++; if (log_od0[35] !== 24'sd21) begin errors++; $display("FAIL rst_pre_od0 got=%0d exp=21", log_od0[35]); end
        checks++; if (log_od1[35] !== 24'sd100) begin errors++; $display("FAIL rst_pre_od1 got=%0d exp=100", log_od1[35]); end
        rst_n = 1'b0;
        #2;
        checks++; if (bus.od0 !== 24'sd0) begin errors++; $display("FAIL rst_od0 got=%0d exp=0", bus.od0); end
        checks++; if (bus.od1 !== 24'sd0) begin errors++; $display("FAIL rst_od1 got=%0d exp=0", bus.od1); end
        checks++; if (bus.ovalid !== 1'b0) begin errors++; $display("FAIL rst_ovalid got=%0b exp=0", bus.ovalid); end
        checks++; if (bus.och !== 2'd0) begin errors++; $display("FAIL rst_och got=%0d exp=0", bus.och); end
        repeat (3) tick();
        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 12; i++) run_cycle(1'b0, 24'sd7);
        for (int i = 0; i < 12; i++) begin
            checks++; if (log_vld[i] !== 1'b0) begin errors++; $display("FAIL presync_ovalid idx=%0d got=%0b exp=0", i, log_vld[i]); end
        end
        s = cyc;
        run_cycle(1'b1, 24'sd7);
        for (int i = 0; i < 35; i++) run_cycle(1'b0, 24'sd7);
        checks++; if (log_vld[s+OFS-1] !== 1'b0) begin errors++; $display("FAIL sync_early_ovalid got=%0b exp=0", log_vld[s+OFS-1]); end
        checks++; if (log_vld[s+OFS] !== 1'b1) begin errors++; $display("FAIL sync_rise_ovalid got=%0b exp=1", log_vld[s+OFS]); end
        checks++; if (log_od1[s+OFS+24] !== 24'sd7) begin errors++; $display("FAIL post_rst_od1 got=%0d exp=7", log_od1[s+OFS+24]); end
        checks++; if (log_od0[s+OFS+24] !== 24'sd0) begin errors++; $display("FAIL post_rst_coef_od0 got=%0d exp=0", log_od0[s+OFS+24]); end
    endtask

    task automatic test_impulse();
        int tbl [6] = '{1000, 2000, 4000, 4000, 2000, 1000};
        logic signed [23:0] e0, e1;
        int idx;
        do_reset();
        set_coefs(1000, 2000, 4000);
        play_impulse(1'b0);
        checks++; if (log_vld[OFS-1] !== 1'b0) begin errors++; $display("FAIL imp_early_ovalid got=%0b exp=0", log_vld[OFS-1]); end
        for (int f = 0; f < 6; f++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                idx = 4 * f + ch + OFS;
                e0  = (ch == 0) ? 24'(tbl[f]) : 24'sd0;
                e1  = (ch == 0 && f == 2) ? 24'sd65536 : 24'sd0;
                checks++; if (log_od0[idx] !== e0) begin errors++; $display("FAIL imp_od0 f=%0d ch=%0d got=%0d exp=%0d", f, ch, log_od0[idx], e0); end
                checks++; if (log_od1[idx] !== e1) begin errors++; $display("FAIL imp_od1 f=%0d ch=%0d got=%0d exp=%0d", f, ch, log_od1[idx], e1); end
                checks++; if (log_och[idx] !== 2'(ch)) begin errors++; $display("FAIL imp_och f=%0d ch=%0d got=%0d", f, ch, log_och[idx]); end
                checks++; if (log_vld[idx] !== 1'b1) begin errors++; $display("FAIL imp_ovalid f=%0d ch=%0d got=%0b exp=1", f, ch, log_vld[idx]); end
            end
        end
    endtask

    task automatic test_dc_gain();
        int idx;
        do_reset();
        set_coefs(16384, 8192, 8192);
        for (int i = 0; i < 88; i++) run_cycle(i == 0, (i < 40) ? 24'sd1000 : -24'sd1);
        bus.sync = 1'b0;
        for (int f = 6; f < 10; f++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                idx = 4 * f + ch + OFS;
                checks++; if (log_od0[idx] !== 24'sd1000) begin errors++; $display("FAIL dc_od0 f=%0d ch=%0d got=%0d exp=1000", f, ch, log_od0[idx]); end
                checks++; if (log_od1[idx] !== 24'sd1000) begin errors++; $display("FAIL dc_od1 f=%0d ch=%0d got=%0d exp=1000", f, ch, log_od1[idx]); end
            end
        end
        for (int f = 16; f < 20; f++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                idx = 4 * f + ch + OFS;
                checks++; if (log_od0[idx] !== -24'sd1) begin errors++; $display("FAIL dcneg_od0 f=%0d ch=%0d got=%0d exp=-1", f, ch, log_od0[idx]); end
                checks++; if (log_od1[idx] !== -24'sd1) begin errors++; $display("FAIL dcneg_od1 f=%0d ch=%0d got=%0d exp=-1", f, ch, log_od1[idx]); end
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [23:0] pmax, nmin;
        int idx;
        pmax = 24'sh7FFFFF;
        nmin = 24'sh800000;
        do_reset();
        set_coefs(131071, 131071, 131071);
        for (int i = 0; i < 88; i++) run_cycle(i == 0, (i < 40) ? pmax : nmin);
        bus.sync = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            idx = 4 * 7 + ch + OFS;
            checks++; if (log_od0[idx] !== pmax) begin errors++; $display("FAIL satpos_od0 ch=%0d got=%0d exp=%0d", ch, log_od0[idx], pmax); end
            checks++; if (log_od1[idx] !== pmax) begin errors++; $display("FAIL satpos_od1 ch=%0d got=%0d exp=%0d", ch, log_od1[idx], pmax); end
            idx = 4 * 17 + ch + OFS;
            checks++; if (log_od0[idx] !== nmin) begin errors++; $display("FAIL satneg_od0 ch=%0d got=%0d exp=%0d", ch, log_od0[idx], nmin); end
            checks++; if (log_od1[idx] !== nmin) begin errors++; $display("FAIL satneg_od1 ch=%0d got=%0d exp=%0d", ch, log_od1[idx], nmin); end
        end
    endtask

    task automatic test_mid_sync();
        int seq [13] = '{0, 1, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
        do_reset();
        set_coefs(1000, 2000, 4000);
        for (int i = 0; i < 20; i++) begin
            run_cycle(i == 0 || i == 2 || i == 6, 24'(100 * (i + 1)));
        end
        bus.sync = 1'b0;
        checks++; if (log_vld[OFS-1] !== 1'b0) begin errors++; $display("FAIL msync_early_ovalid got=%0b exp=0", log_vld[OFS-1]); end
        for (int i = 0; i < 13; i++) begin
            checks++; if (log_och[i+OFS] !== 2'(seq[i])) begin errors++; $display("FAIL msync_och i=%0d got=%0d exp=%0d", i, log_och[i+OFS], seq[i]); end
            checks++; if (log_vld[i+OFS] !== 1'b1) begin errors++; $display("FAIL msync_ovalid i=%0d got=%0b exp=1", i, log_vld[i+OFS]); end
        end
        checks++; if (log_od1[6+OFS] !== 24'sd100) begin errors++; $display("FAIL msync_hist_od1 got=%0d exp=100", log_od1[6+OFS]); end
    endtask

    task automatic test_tap_reload();
        int tbl [6] = '{1000, -5000, 4000, 4000, -5000, 1000};
        int idx;
        do_reset();
        set_coefs(1000, 2000, 4000);
        play_impulse(1'b1);
        for (int f = 0; f < 6; f++) begin
            idx = 4 * f + OFS;
            checks++; if (log_od0[idx] !== 24'(tbl[f])) begin errors++; $display("FAIL reload_od0 f=%0d got=%0d exp=%0d", f, log_od0[idx], tbl[f]); end
            checks++; if (log_od0[idx+1] !== 24'sd0) begin errors++; $display("FAIL reload_ch1_od0 f=%0d got=%0d exp=0", f, log_od0[idx+1]); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc_gain();
        test_saturation();
        test_mid_sync();
        test_tap_reload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/halfband_interp.md
Name: halfband_interp

Overview:
- Halfband interpolate-by-2 FIR for TDM multichannel streams. It is the transmit-side counterpart of the halfband decimator.
- One input sample per clock, channels rotating 0..NCH-1. Each input produces two output phases on the same cycle:
  - a FIR phase from the symmetric odd taps;
  - a centre phase, which is the delayed input at unity gain.
- Used ahead of DAC/upconversion; stages cascade by re-serialising od0/od1.

Parameters:
- NCH, 4, number of TDM channels; one sample per channel per frame of NCH clocks.
- NDSP, 3, number of unique FIR-phase coefficients; full halfband length is 4*NDSP-1.

Ports:
- c  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- sync  input  1  marks the current id sample as channel 0
- id  input  24  signed input sample for the current channel
- tap  input  18  signed coefficient, Q1.17
- load_tap  input  NDSP  one-hot coefficient write strobe; bit k writes coefficient k
- od0  output  24  signed FIR-phase output (earlier of the output pair)
- od1  output  24  signed centre-phase output (later of the output pair)
- ovalid  output  1  od0/od1/och valid
- och  output  max(1,$clog2(NCH))  channel of the current od0/od1

Behaviour:
- Reset:
  - rst_n low forces immediately: od0=0, od1=0, ovalid=0, och=0, channel counter=0, all coefficients=0, all history=0.
  - Reset asserted mid-stream discards all pipeline contents.
- Channel counter:
  - sync=1: the current sample is channel 0 and the counter loads 1 (or 0 when NCH=1).
  - Otherwise the counter increments and wraps NCH-1 -> 0.
  - sync on a cycle where the counter is already 0 changes nothing.
  - Mid-frame sync re-aligns the counter; history is not cleared.
- Stream: no backpressure; id is sampled every clock.
- Start-up: after reset, ovalid stays 0 and nothing is emitted until the first sync. From then on, ovalid=1 every cycle, starting exactly LAT cycles after that sync.
- History: per channel, the last 2*NDSP samples x[n]..x[n-2*NDSP+1] are kept in shift/delay storage indexed by channel.
- Coefficients: on a clock edge with load_tap[k]=1, coef[k] <= tap. Multiple bits may be set and all load. A change takes effect for samples entering the multiply stage after the edge; there is no glitch protection.
- FIR phase:
  - acc = sum_{k=0}^{NDSP-1} coef[k] * (x[n-k] + x[n-2*NDSP+1+k]).
  - Pre-add is 25-bit, products 43-bit, accumulator 48-bit; no intermediate truncation.
  - od0 = sat24((acc + 2^15) >>> 16), which includes the interpolation gain of 2.
  - Round half up. Saturate to the range [-8388608, 8388607].
- Centre phase: od1 = x[n-NDSP+1] exactly, with no arithmetic.
- Latency:
  - Input for channel ch at cycle t produces od0/od1 with och=ch at cycle t+LAT, where LAT = NDSP+3.
  - LAT is fixed and independent of NCH.
  - och follows the input channel sequence delayed by LAT, including mid-frame sync re-alignment.
- Implementation: pipelined pre-add/multiply/accumulate in a systolic chain, one stage per coefficient, mappable to DSP48E1 without changing observable behaviour. The centre path is delayed to match.

Test Plan:
- Reset:
  - Stream active, pulse rst_n low for 3 cycles -> od0=od1=0, ovalid=0 immediately.
  - Before any sync, ovalid stays 0.
  - With sync at cycle s, ovalid rises at s+6 (NDSP=3).
- Impulse (NCH=4, NDSP=3, coef=1000,2000,4000):
  - Stimulus: ch0 id=65536 at frame 0, all else 0.
  - Required ch0 od0 over frames 0..5: 1000, 2000, 4000, 4000, 2000, 1000.
  - Required ch0 od1: 65536 at frame 2, 0 otherwise.
  - Channels 1..3 all 0.
- DC gain:
  - Stimulus: coef=16384,8192,8192, all channels constant 1000.
  - Required from frame 6 on: od0=od1=1000 on every channel.
  - Stimulus: constant -1. Required: od0=-1, od1=-1.
- Saturation:
  - coef=131071,131071,131071 with constant 8388607 -> od0=8388607.
  - Same coef with constant -8388608 -> od0=-8388608.
  - In both cases od1 equals the input value.
- Mid-frame sync:
  - Stimulus: sync re-asserted when the counter is 2.
  - Required: och sequence 0,1,0,1,2,3,... appears exactly LAT cycles later with no ovalid gap.
  - Stimulus: sync asserted when the counter is already 0. Required: no change.
- Tap reload:
  - Stimulus: load_tap=3'b010 with tap=-5000 mid-stream under the impulse test.
  - Required: later outputs use coef[1]=-5000 (frame 1 response -5000). coef[0] and coef[2] are unchanged.
